// File: rtl/pdm_interp_pkg.sv
// Shared audio definitions for the sample path feeding the PDM modulator.
package pdm_interp_pkg;

   localparam int         AUDIO_WIDTH    = 8;
   localparam logic [7:0] AUDIO_MIDSCALE = 8'h80;
   localparam int         SAMPLE_DIV     = 1000;

endpackage

// File: rtl/pdm_interp.sv
// Linear interpolator: ramps an offset-binary sample from its previous value to each
// new input in 2^STEP_LOG2 steps, paced by step_en, ahead of the PDM modulator.
module pdm_interp
   import pdm_interp_pkg::*;
#(
   parameter int INPUT_WIDTH = AUDIO_WIDTH,
   parameter int STEP_LOG2   = 4,
   parameter bit SIGNED_IN   = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [INPUT_WIDTH-1:0] sample_in,
   input  logic                   sample_valid,
   input  logic                   step_en,
   output logic [INPUT_WIDTH-1:0] sample_out,
   output logic                   ramp_active,
   output logic                   overrun
);

   localparam int W  = INPUT_WIDTH;
   localparam int S  = STEP_LOG2;
   localparam int AW = W + S;

   localparam logic [W-1:0] MIDSCALE = {1'b1, {(W-1){1'b0}}};
   localparam logic [S:0]   PH_LAST  = {1'b0, {S{1'b1}}};

   typedef enum logic {
      IDLE = 1'b0,
      RAMP = 1'b1
   } state_t;

   state_t               state;
   logic [AW-1:0]        acc;
   logic signed [W:0]    delta;
   logic [S:0]           phase;

   logic [W-1:0]         tgt;
   logic signed [W:0]    delta_new;
   logic [AW-1:0]        delta_ext;

   always_comb begin
      tgt       = SIGNED_IN ? (sample_in ^ MIDSCALE) : sample_in;
      delta_new = $signed({1'b0, tgt}) - $signed({1'b0, sample_out});
      // Sign extension to the accumulator width; the add wraps modulo 2^AW by design.
      delta_ext = {{(S-1){delta[W]}}, delta};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc     <= {MIDSCALE, {S{1'b0}}};
         delta   <= '0;
         phase   <= '0;
         state   <= IDLE;
         overrun <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (sample_valid) begin
            acc     <= {sample_out, {S{1'b0}}};
            delta   <= delta_new;
            phase   <= '0;
            state   <= RAMP;
            overrun <= (state == RAMP);
         end else if (step_en && state == RAMP) begin
            acc   <= acc + delta_ext;
            phase <= phase + 1'b1;
            if (phase == PH_LAST)
               state <= IDLE;
         end
      end
   end

   assign sample_out  = acc[AW-1:S];
   assign ramp_active = (state == RAMP);

endmodule

// File: tb/tb_pdm_interp.sv
// Bench for pdm_interp: signed and unsigned instances (W=8, S=2) driven in parallel
// and compared every cycle with a closed-form ramp model.
module tb_pdm_interp;

   localparam int W     = 8;
   localparam int S     = 2;
   localparam int STEPS = 1 << S;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] sample_in;
   logic         sample_valid;
   logic         step_en;
   logic [W-1:0] out_s, out_u;
   logic         act_s, act_u, ovr_s, ovr_u;

   int n_cmp = 0;
   int n_err = 0;

   int m_start [2];
   int m_tgt   [2];
   int m_k     [2];
   bit m_ovr   [2];

   always #5 clk = ~clk;

   pdm_interp #(.INPUT_WIDTH(W), .STEP_LOG2(S), .SIGNED_IN(1'b1)) u_s (
      .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
      .step_en(step_en), .sample_out(out_s), .ramp_active(act_s), .overrun(ovr_s));

   pdm_interp #(.INPUT_WIDTH(W), .STEP_LOG2(S), .SIGNED_IN(1'b0)) u_u (
      .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
      .step_en(step_en), .sample_out(out_u), .ramp_active(act_u), .overrun(ovr_u));

   // Output after k of STEPS steps: start + k/STEPS of the way to the target, floored.
   function automatic int m_out(input int i);
      return (m_start[i] * STEPS + m_k[i] * (m_tgt[i] - m_start[i])) / STEPS;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string step);
      chk({step, " s.out"}, 16'(out_s), 16'(m_out(0)));
      chk({step, " s.act"}, 16'(act_s), 16'(m_k[0] < STEPS));
      chk({step, " s.ovr"}, 16'(ovr_s), 16'(m_ovr[0]));
      chk({step, " u.out"}, 16'(out_u), 16'(m_out(1)));
      chk({step, " u.act"}, 16'(act_u), 16'(m_k[1] < STEPS));
      chk({step, " u.ovr"}, 16'(ovr_u), 16'(m_ovr[1]));
   endtask

   task automatic cycle(input string step, input bit r, input bit v, input bit s,
                        input logic [W-1:0] d);
      int cur;
      reset = r; sample_valid = v; step_en = s; sample_in = d;
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (r) begin
            m_start[i] = 128; m_tgt[i] = 128; m_k[i] = STEPS; m_ovr[i] = 1'b0;
         end else if (v) begin
            cur        = m_out(i);
            m_ovr[i]   = (m_k[i] < STEPS);
            m_start[i] = cur;
            m_tgt[i]   = (i == 0) ? int'(d ^ 8'h80) : int'(d);
            m_k[i]     = 0;
         end else begin
            m_ovr[i] = 1'b0;
            if (s && m_k[i] < STEPS) m_k[i]++;
         end
      end
      #1;
      check_all(step);
   endtask

   task automatic steps(input string step, input int n, input int gap);
      for (int j = 0; j < n; j++) begin
         cycle(step, 0, 0, 1, 8'h00);
         for (int g = 0; g < gap; g++) cycle(step, 0, 0, 0, 8'h00);
      end
   endtask

   initial begin
      logic [W-1:0] rd;
      bit rr, rv, rs;
      for (int i = 0; i < 2; i++) begin
         m_start[i] = 128; m_tgt[i] = 128; m_k[i] = STEPS; m_ovr[i] = 1'b0;
      end
      reset = 1'b1; sample_valid = 1'b1; step_en = 1'b1; sample_in = 8'h11;

      // Reset held with strobes active
      for (int j = 0; j < 3; j++) cycle("reset", 1, 1, 1, 8'($urandom));
      chk("reset midscale", 16'(out_s), 16'h80);
      cycle("release", 0, 0, 1, 8'h00);

      // Basic ramp 0x80 -> 0xFF, then an extra step in IDLE
      cycle("load7f", 0, 1, 0, 8'h7F);
      steps("ramp", 4, 4);
      chk("ramp end", 16'(out_s), 16'hFF);
      steps("idle step", 1, 2);

      // Overrun: new sample after two of four steps
      cycle("rst2", 1, 0, 0, 8'h00);
      cycle("load7f b", 0, 1, 0, 8'h7F);
      steps("half", 2, 1);
      cycle("overrun", 0, 1, 0, 8'h80);
      steps("ramp2", 4, 1);
      chk("ramp2 end", 16'(out_s), 16'h00);

      // Load and step together: load wins
      cycle("both", 0, 1, 1, 8'h40);
      steps("after both", 4, 0);

      // Unsigned instance loads 0x00 from midscale
      cycle("rst3", 1, 0, 0, 8'h00);
      cycle("load00", 0, 1, 0, 8'h00);
      steps("uramp", 4, 0);
      chk("uramp end", 16'(out_u), 16'h00);

      // Reset in the middle of a ramp, then steps with no load
      cycle("load mid", 0, 1, 0, 8'h7F);
      steps("one", 1, 0);
      cycle("rst mid", 1, 0, 0, 8'h00);
      chk("rst mid out", 16'(out_s), 16'h80);
      steps("dead steps", 3, 1);

      // Randomised traffic
      for (int n = 0; n < 600; n++) begin
         rr = ($urandom % 150) == 0;
         rv = ($urandom % 10) == 0;
         rs = ($urandom % 3) == 0;
         rd = 8'($urandom);
         cycle("rand", rr, rv, rs, rd);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
